// File: rtl/adbg_burst_pkg.sv
// Shared types and constants for the OR1K debug burst sequencer.
// The CRC helper is used only when ADBG_BURST_CRC_EN is defined.
package adbg_burst_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} burst_state_e;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Reflected CRC-32, one full word per call; xoring the word in first equals bit-serial LSB-first.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc ^ data;
    for (int i = 0; i < 32; i++) c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    return c;
  endfunction
endpackage

// File: rtl/adbg_or1k_burst_seq_if.sv
// Command, write/read stream and BIU signals of the burst sequencer.
// slave = sequencer side, master = decoder/BIU/environment side.
interface adbg_or1k_burst_seq_if #(parameter int LEN_W = 16) ();
  logic             cmd_valid_i, cmd_ready_o, cmd_rd_wrn_i;
  logic [3:0]       cmd_cpu_i;
  logic [31:0]      cmd_addr_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             abort_i;
  logic             wdata_valid_i, wdata_ready_o;
  logic [31:0]      wdata_i;
  logic             rdata_valid_o, rdata_ready_i;
  logic [31:0]      rdata_o;
  logic             busy_o, done_o, err_o;
  logic [31:0]      crc_o;
  logic [3:0]       biu_cpu_select_o;
  logic [31:0]      biu_addr_o, biu_data_o, biu_data_i;
  logic             biu_rd_wrn_o, biu_strobe_o, biu_rdy_i;

  modport slave (
    input  cmd_valid_i, cmd_rd_wrn_i, cmd_cpu_i, cmd_addr_i, cmd_len_i, abort_i,
           wdata_valid_i, wdata_i, rdata_ready_i, biu_rdy_i, biu_data_i,
    output cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, busy_o, done_o, err_o,
           crc_o, biu_cpu_select_o, biu_addr_o, biu_data_o, biu_rd_wrn_o, biu_strobe_o
  );

  modport master (
    output cmd_valid_i, cmd_rd_wrn_i, cmd_cpu_i, cmd_addr_i, cmd_len_i, abort_i,
           wdata_valid_i, wdata_i, rdata_ready_i, biu_rdy_i, biu_data_i,
    input  cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, busy_o, done_o, err_o,
           crc_o, biu_cpu_select_o, biu_addr_o, biu_data_o, biu_rd_wrn_o, biu_strobe_o
  );
endinterface

// File: rtl/adbg_burst_crc32.sv
// Running CRC-32 register over transferred words; reloads on init, advances one word per en.
module adbg_burst_crc32
  import adbg_burst_pkg::*;
(
  input  logic        tck_i,
  input  logic        trstn_i,
  input  logic        init,
  input  logic        en,
  input  logic [31:0] data,
  output logic [31:0] crc
);
  logic [31:0] crc_q;

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i)  crc_q <= CRC32_INIT;
    else if (init) crc_q <= CRC32_INIT;
    else if (en)   crc_q <= crc32_word(crc_q, data);
  end

  assign crc = crc_q;
endmodule

// File: rtl/adbg_or1k_burst_seq.sv
// Burst sequencer: splits one burst command into single-word BIU strobe/ready accesses.
// Optional running CRC of transferred words under ADBG_BURST_CRC_EN.
module adbg_or1k_burst_seq
  import adbg_burst_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input logic tck_i,
  input logic trstn_i,
  adbg_or1k_burst_seq_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PONE = 1;

  burst_state_e     state_q;
  logic [3:0]       cpu_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] rem_q;
  logic             rd_q, abort_q, done_q, err_q;

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q, fcnt;
  logic        empty, full, cmd_ready, accept, strobe, xfer, push, pop;

  // Pointers carry one extra bit so count == FIFO_DEPTH is distinguishable from empty.
  assign fcnt  = wr_ptr_q - rd_ptr_q;
  assign empty = (fcnt == '0);
  assign full  = fcnt[PW];

  assign cmd_ready = (state_q == IDLE) && empty;
  assign accept    = bus.cmd_valid_i && cmd_ready;
  // Read issue reserves its FIFO slot up front, so a push can never hit a full FIFO.
  assign strobe    = (state_q == ISSUE) && bus.biu_rdy_i && !bus.abort_i &&
                     (rd_q ? !full : bus.wdata_valid_i);
  assign xfer      = (state_q == WAIT) && bus.biu_rdy_i;
  assign push      = xfer && rd_q;
  assign pop       = bus.rdata_ready_i && !empty;

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      state_q <= IDLE;
      cpu_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      rd_q    <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          cpu_q   <= bus.cmd_cpu_i;
          addr_q  <= bus.cmd_addr_i;
          rem_q   <= bus.cmd_len_i;
          rd_q    <= bus.cmd_rd_wrn_i;
          abort_q <= 1'b0;
          if (bus.cmd_len_i == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.abort_i) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (strobe) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // An issued access always completes; abort is only acted on once rdy returns.
          if (bus.abort_i) abort_q <= 1'b1;
          if (bus.biu_rdy_i) begin
            addr_q <= addr_q + 32'd1;
            rem_q  <= rem_q - LEN_W'(1);
            if (abort_q || bus.abort_i || rem_q == LEN_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= abort_q || bus.abort_i;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PONE;
    end
  end

  always_ff @(posedge tck_i) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= bus.biu_data_i;
  end

  assign bus.cmd_ready_o      = cmd_ready;
  assign bus.busy_o           = (state_q != IDLE);
  assign bus.done_o           = done_q;
  assign bus.err_o            = err_q;
  assign bus.rdata_valid_o    = !empty;
  assign bus.rdata_o          = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign bus.wdata_ready_o    = strobe && !rd_q;
  assign bus.biu_strobe_o     = strobe;
  assign bus.biu_cpu_select_o = cpu_q;
  assign bus.biu_addr_o       = addr_q;
  assign bus.biu_rd_wrn_o     = rd_q;
  assign bus.biu_data_o       = ((state_q == ISSUE) && !rd_q) ? bus.wdata_i : '0;

`ifdef ADBG_BURST_CRC_EN
  logic [31:0] wdata_q, crc;

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i)    wdata_q <= '0;
    else if (strobe) wdata_q <= bus.wdata_i;
  end

  adbg_burst_crc32 u_crc (
    .tck_i  (tck_i),
    .trstn_i(trstn_i),
    .init   (accept),
    .en     (xfer),
    .data   (rd_q ? bus.biu_data_i : wdata_q),
    .crc    (crc)
  );
  assign bus.crc_o = crc;
`else
  assign bus.crc_o = CRC32_INIT;
`endif
endmodule

// File: tb/tb_adbg_or1k_burst_seq.sv
// Directed bench for adbg_or1k_burst_seq with a latency BIU model and scoreboard queues.
module tb_adbg_or1k_burst_seq;
  logic tck = 1'b0;
  logic trstn = 1'b0;
  int total = 0;
  int bad = 0;
  int n_strobe = 0, n_wready = 0, n_done = 0;
  int s0, w0, d0;
  logic found, errv;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_wd_q[$];
  logic [31:0] exp_rd_q[$];

  adbg_or1k_burst_seq_if #(.LEN_W(16)) bus ();

  adbg_or1k_burst_seq #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
    .tck_i  (tck),
    .trstn_i(trstn),
    .bus    (bus.slave)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [31:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 32; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  // BIU: drops rdy the cycle after a strobe, keeps it low 4 cycles, returns 0xA0 + addr.
  int          lat_cnt;
  logic [31:0] biu_a;
  always @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      bus.biu_rdy_i  <= 1'b1;
      bus.biu_data_i <= '0;
      lat_cnt        <= 0;
      biu_a          <= '0;
    end else if (bus.biu_strobe_o) begin
      bus.biu_rdy_i <= 1'b0;
      lat_cnt       <= 4;
      biu_a         <= bus.biu_addr_o;
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        bus.biu_rdy_i  <= 1'b1;
        bus.biu_data_i <= 32'hA0 + biu_a;
      end
    end
  end

  always @(negedge tck) if (trstn) begin
    if (bus.biu_strobe_o) begin
      n_strobe++;
      if (exp_addr_q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
      else chk("biu_addr", bus.biu_addr_o, exp_addr_q.pop_front());
      if (!bus.biu_rd_wrn_o) begin
        chk("wready_with_strobe", 32'(bus.wdata_ready_o), 32'd1);
        if (exp_wd_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else chk("biu_data", bus.biu_data_o, exp_wd_q.pop_front());
      end
    end
    if (bus.wdata_ready_o) n_wready++;
    if (bus.rdata_valid_o && bus.rdata_ready_i) begin
      if (exp_rd_q.size() == 0) chk("unexpected_rdata", 32'd1, 32'd0);
      else chk("rdata", bus.rdata_o, exp_rd_q.pop_front());
    end
    if (bus.done_o) n_done++;
  end

  task automatic send_cmd(input logic rd, input logic [3:0] cpu, input logic [31:0] addr,
                          input logic [15:0] len);
    int n;
    n = 0;
    while (!bus.cmd_ready_o && n < 200) begin
      @(posedge tck); #1;
      n++;
    end
    if (n >= 200) chk("cmd_ready_timeout", 32'd0, 32'd1);
    bus.cmd_rd_wrn_i = rd;
    bus.cmd_cpu_i    = cpu;
    bus.cmd_addr_i   = addr;
    bus.cmd_len_i    = len;
    bus.cmd_valid_i  = 1'b1;
    @(posedge tck); #1;
    bus.cmd_valid_i  = 1'b0;
  endtask

  task automatic wait_done(output logic err);
    found = 1'b0;
    err   = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge tck);
      if (bus.done_o) begin
        found = 1'b1;
        err   = bus.err_o;
      end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_word(input logic [31:0] w, input int gap);
    logic got;
    repeat (gap) @(posedge tck);
    #1;
    bus.wdata_i       = w;
    bus.wdata_valid_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge tck);
      if (bus.wdata_ready_o) got = 1'b1;
    end
    if (!got) chk("wready_timeout", 32'd0, 32'd1);
    @(posedge tck); #1;
    bus.wdata_valid_i = 1'b0;
  endtask

  initial begin
    bus.cmd_valid_i = 0; bus.cmd_rd_wrn_i = 0; bus.cmd_cpu_i = 0; bus.cmd_addr_i = 0;
    bus.cmd_len_i = 0; bus.abort_i = 0; bus.wdata_valid_i = 0; bus.wdata_i = 0;
    bus.rdata_ready_i = 1'b1;
    repeat (3) @(posedge tck);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_crc", bus.crc_o, 32'hFFFFFFFF);
    chk("rst_strobe", 32'(bus.biu_strobe_o), 32'd0);
    chk("rst_rvalid", 32'(bus.rdata_valid_o), 32'd0);
    chk("rst_addr", bus.biu_addr_o, 32'd0);
    @(negedge tck) trstn = 1'b1;
    @(posedge tck); #1;

    // Read burst of 3 at 0x2000
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(32'h2000 + i);
      exp_rd_q.push_back(32'hA0 + 32'h2000 + i);
    end
    s0 = n_strobe; d0 = n_done;
    send_cmd(1'b1, 4'h3, 32'h2000, 16'd3);
    @(negedge tck);
    chk("rd_first_strobe", 32'(bus.biu_strobe_o), 32'd1);
    chk("rd_cpu_sel", 32'(bus.biu_cpu_select_o), 32'h3);
    wait_done(errv);
    chk("rd_err", 32'(errv), 32'd0);
    repeat (3) @(posedge tck);
    #1;
    chk("rd_strobes", 32'(n_strobe - s0), 32'd3);
    chk("rd_done_cnt", 32'(n_done - d0), 32'd1);
    chk("rd_rdata_left", 32'(exp_rd_q.size()), 32'd0);

    // Write burst of 2, data gapped by 5 cycles
    exp_addr_q.push_back(32'h100); exp_wd_q.push_back(32'hDEAD0001);
    exp_addr_q.push_back(32'h101); exp_wd_q.push_back(32'hBEEF0002);
    s0 = n_strobe; w0 = n_wready;
    send_cmd(1'b0, 4'h1, 32'h100, 16'd2);
    repeat (5) @(posedge tck);
    #1;
    chk("wr_no_strobe_gap", 32'(n_strobe - s0), 32'd0);
    drive_word(32'hDEAD0001, 0);
    drive_word(32'hBEEF0002, 5);
    wait_done(errv);
    chk("wr_err", 32'(errv), 32'd0);
    chk("wr_strobes", 32'(n_strobe - s0), 32'd2);
    chk("wr_wready_pulses", 32'(n_wready - w0), 32'd2);

    // Backpressure: read 6 words with the consumer stalled
    bus.rdata_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_addr_q.push_back(32'h3000 + i);
      exp_rd_q.push_back(32'hA0 + 32'h3000 + i);
    end
    s0 = n_strobe;
    send_cmd(1'b1, 4'h2, 32'h3000, 16'd6);
    repeat (60) @(posedge tck);
    #1;
    chk("bp_stall_strobes", 32'(n_strobe - s0), 32'd4);
    chk("bp_busy", 32'(bus.busy_o), 32'd1);
    chk("bp_rvalid", 32'(bus.rdata_valid_o), 32'd1);
    bus.rdata_ready_i = 1'b1;
    wait_done(errv);
    chk("bp_err", 32'(errv), 32'd0);
    repeat (8) @(posedge tck);
    #1;
    chk("bp_strobes", 32'(n_strobe - s0), 32'd6);
    chk("bp_rdata_left", 32'(exp_rd_q.size()), 32'd0);

    // Zero length: done and err one cycle after accept, no BIU access
    s0 = n_strobe;
    send_cmd(1'b1, 4'h0, 32'h10, 16'd0);
    @(negedge tck);
    chk("z_done", 32'(bus.done_o), 32'd1);
    chk("z_err", 32'(bus.err_o), 32'd1);
    repeat (4) @(posedge tck);
    #1;
    chk("z_strobes", 32'(n_strobe - s0), 32'd0);

    // Address wrap
    exp_addr_q.push_back(32'hFFFFFFFF); exp_rd_q.push_back(32'hA0 + 32'hFFFFFFFF);
    exp_addr_q.push_back(32'h00000000); exp_rd_q.push_back(32'hA0);
    send_cmd(1'b1, 4'h0, 32'hFFFFFFFF, 16'd2);
    wait_done(errv);
    chk("wrap_err", 32'(errv), 32'd0);
    repeat (3) @(posedge tck);
    #1;
    chk("wrap_addr_left", 32'(exp_addr_q.size()), 32'd0);

    // Abort during WAIT of word 2 of 5
    for (int i = 0; i < 2; i++) begin
      exp_addr_q.push_back(32'h4000 + i);
      exp_rd_q.push_back(32'hA0 + 32'h4000 + i);
    end
    s0 = n_strobe;
    send_cmd(1'b1, 4'h0, 32'h4000, 16'd5);
    for (int i = 0; i < 100 && (n_strobe - s0) < 2; i++) @(negedge tck);
    @(posedge tck); #1;
    bus.abort_i = 1'b1;
    wait_done(errv);
    chk("abort_err", 32'(errv), 32'd1);
    @(posedge tck); #1;
    bus.abort_i = 1'b0;
    repeat (8) @(posedge tck);
    #1;
    chk("abort_strobes", 32'(n_strobe - s0), 32'd2);
    chk("abort_rdata_left", 32'(exp_rd_q.size()), 32'd0);

    // Reset in the middle of WAIT
    exp_addr_q.push_back(32'h5000);
    s0 = n_strobe; d0 = n_done;
    send_cmd(1'b1, 4'h5, 32'h5000, 16'd3);
    for (int i = 0; i < 100 && (n_strobe - s0) < 1; i++) @(negedge tck);
    @(posedge tck); #1;
    @(posedge tck); #1;
    trstn = 1'b0;
    #1;
    chk("mr_busy", 32'(bus.busy_o), 32'd0);
    chk("mr_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("mr_done", 32'(bus.done_o), 32'd0);
    chk("mr_crc", bus.crc_o, 32'hFFFFFFFF);
    chk("mr_cpu", 32'(bus.biu_cpu_select_o), 32'd0);
    @(negedge tck) trstn = 1'b1;
    repeat (20) @(posedge tck);
    #1;
    chk("mr_no_done", 32'(n_done - d0), 32'd0);
    chk("mr_strobes", 32'(n_strobe - s0), 32'd1);

    // CRC of a single written zero word
    exp_addr_q.push_back(32'h6000); exp_wd_q.push_back(32'h0);
    send_cmd(1'b0, 4'h0, 32'h6000, 16'd1);
    drive_word(32'h0, 0);
    wait_done(errv);
    chk("crc_err", 32'(errv), 32'd0);
`ifdef ADBG_BURST_CRC_EN
    chk("crc_value", bus.crc_o, ref_crc(32'hFFFFFFFF, 32'h0));
`else
    chk("crc_value", bus.crc_o, 32'hFFFFFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adbg_or1k_burst_seq.md
# adbg_or1k_burst_seq

TCK-domain burst sequencer sitting directly upstream of the OR1K SPR bus interface unit in the advanced debug interface. Accepts one burst command (CPU select, start address, word count, direction) from the JTAG command decoder. Breaks it into single-word strobe/ready transactions on the BIU port, auto-incrementing the address. Streams write data in and read data out through valid/ready ports, buffering read words in a small FIFO.

## Interface
- `FIFO_DEPTH`, default 4: read-data FIFO entries; power of 2, minimum 2.
- `LEN_W`, default 16: width of the burst word count.
- Clock is `tck_i`; reset is `trstn_i`, asynchronous, active-low.
- `tck_i` in 1: JTAG TCK; all logic on rising edge.
- `trstn_i` in 1: asynchronous active-low reset.
- `cmd_valid_i` in 1: burst command present.
- `cmd_ready_o` out 1: command accepted when both this and valid are high.
- `cmd_rd_wrn_i` in 1: 1 = read burst, 0 = write burst.
- `cmd_cpu_i` in 4: target core select.
- `cmd_addr_i` in 32: first SPR address.
- `cmd_len_i` in LEN_W: number of words.
- `abort_i` in 1: terminate the burst early.
- `wdata_valid_i` in 1: write word present.
- `wdata_ready_o` out 1: write word consumed this cycle.
- `wdata_i` in 32: write word.
- `rdata_valid_o` out 1: FIFO not empty.
- `rdata_ready_i` in 1: consumer pops a word.
- `rdata_o` out 32: FIFO head.
- `busy_o` out 1: burst in progress.
- `done_o` out 1: one-cycle pulse at burst end.
- `err_o` out 1: one-cycle pulse together with `done_o` on a zero-length or aborted burst.
- `crc_o` out 32: running CRC of transferred words.
- `biu_cpu_select_o` out 4: core select to the BIU.
- `biu_addr_o` out 32: address to the BIU.
- `biu_data_o` out 32: write data to the BIU.
- `biu_rd_wrn_o` out 1: direction to the BIU.
- `biu_strobe_o` out 1: one-cycle transaction request.
- `biu_rdy_i` in 1: BIU ready.
- `biu_data_i` in 32: BIU read data.

## Operation
- States are `IDLE`, `ISSUE`, `WAIT` and `DONE`.
- **`IDLE`:** `cmd_ready_o` = 1 only when the FIFO is empty.
  - On accept, latch cpu, addr, len and direction, reset the CRC, and go to `ISSUE`.
  - If `cmd_len_i` = 0, go to `DONE` with the error flag set; no BIU access.
- **`ISSUE`:** `biu_strobe_o` is combinational, high only when `biu_rdy_i` = 1 and one of:
  - write: `wdata_valid_i` = 1;
  - read: FIFO count < `FIFO_DEPTH`.
- **Write data path in `ISSUE`:** `wdata_ready_o` pulses in the strobe cycle. `biu_data_o` = `wdata_i` (pass-through, registered in the BIU). On strobe, go to `WAIT`.
- **`WAIT`:** exit on `biu_rdy_i` = 1. Then:
  - read: push `biu_data_i` into the FIFO;
  - CRC update with the transferred word;
  - address +1, modulo 2^32;
  - remaining count −1;
  - go to `DONE` if remaining = 0, else `ISSUE`.
- **`DONE`:** `done_o` pulses (plus `err_o` if the error flag is set), then go to `IDLE`.
- **Abort:**
  - Seen in `ISSUE`: go to `DONE` with the error flag set.
  - Seen in `WAIT`: held pending until `biu_rdy_i` returns, since an issued access always completes; the read word is still pushed, then go to `DONE` with the error flag set.
  - The FIFO is not flushed.
- **FIFO:** simultaneous push and pop leaves the count unchanged. Pop when empty is ignored. Push never happens when full, because space is reserved at issue.
- **`busy_o`** = state ≠ `IDLE`.
- **Reset values:** all outputs 0 except `cmd_ready_o` = 1 and `crc_o` = 32'hFFFFFFFF. State `IDLE`, FIFO empty. Reset mid-burst discards everything; no `done_o` is produced.

## Timing
- Command accept to first strobe: 1 cycle minimum (strobe in the cycle after accept).
- Strobe to BIU `rdy` low: the next cycle. `WAIT` samples `biu_rdy_i` from the cycle after the strobe onward.
- Per word: 1 `ISSUE` cycle plus the BIU round trip (≥ 2 cycles of sync per direction).
- Last `rdy` to `done_o`: 1 cycle.
- A read word is visible on `rdata_o` the cycle after the `rdy` sample.

## Configuration
- **`ADBG_BURST_CRC_EN` defined:** `crc_o` is a CRC-32 over each transferred word.
  - Polynomial 0xEDB88320, reflected, LSB first.
  - Initialised to 32'hFFFFFFFF at command accept.
  - One word per cycle, not inverted at the end.
- **Not defined:** `crc_o` is tied to 32'hFFFFFFFF and no CRC logic is instantiated.

## Structure
- Package `adbg_burst_pkg` holds:
  - state enum `burst_state_e`;
  - `CRC32_POLY` = 32'hEDB88320;
  - `CRC32_INIT` = 32'hFFFFFFFF.
- Sub-module `adbg_burst_crc32`: word-parallel CRC update, combinational next-value plus register, instantiated only under `ADBG_BURST_CRC_EN`.
- The FIFO is inline.

## Test plan
- **Read burst:** len 3, addr 0x2000, BIU model 4-cycle latency returning 0xA0 + addr → three strobes at 0x2000/0x2001/0x2002; `rdata_o` yields 0xA0+0x2000..2002; one `done_o`, `err_o` = 0.
- **Write burst:** len 2, `wdata_valid_i` gapped by 5 cycles → strobe only when valid; `biu_data_o` matches each word; `wdata_ready_o` pulses exactly twice.
- **Backpressure:** read len 6, FIFO_DEPTH 4, `rdata_ready_i` = 0 → exactly 4 strobes then stall. Releasing ready → remaining 2 complete, 6 words in order.
- **Zero length and wrap:**
  - len 0 → no strobe; `done_o` and `err_o` together one cycle after accept.
  - len 2 at 0xFFFFFFFF → second address 0x00000000.
- **Abort:** assert `abort_i` in `WAIT` of word 2 of 5 → word 2 completes and is pushed; no third strobe; `done_o` + `err_o`.
- **Reset and CRC:** `trstn_i` low mid-`WAIT` → all outputs at reset values, no `done_o`. With `ADBG_BURST_CRC_EN`, write of the single word 0x00000000 → `crc_o` equals the reference-model value.
